inst_queue: RTL and testbench

- Instruction queue directly upstream of vinst_ctl in the LAP core.
- Replaces the constant `finst` / `ifavail` tie-off.
- Host side: valid/ready write port on clk; buffers packed sa_inst_t words in a FIFO.
- Consumer side: first-word-fall-through `inst` / `iavail` to vinst_ctl, popped by `ird`. Adds flush, level and almost-full status, a sticky underflow error and a retired-instruction counter.

---
 rtl/inst_queue.sv | 143 ++++++++++++++
 tb/tb_inst_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// First-word-fall-through instruction queue feeding vinst_ctl: host valid/ready push side,
// inst/iavail/ird pop side, flush, level/almost_full status, sticky underflow and retired counter.
// Optional starvation perf counter enabled by defining INST_QUEUE_STARVE_CNT_EN.
module inst_queue #(
  parameter int INST_WIDTH = 148,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hwr_valid,
  input  logic [INST_WIDTH-1:0]      hwr_data,
  output logic                       hwr_ready,
  input  logic                       flush,
  output logic [INST_WIDTH-1:0]      inst,
  output logic                       iavail,
  input  logic                       ird,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       err_udf,
  output logic [CNT_WIDTH-1:0]       retired,
  output logic [CNT_WIDTH-1:0]       starve_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(DEPTH - AF_MARGIN);

  logic [INST_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  err_udf_q, err_udf_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic                  push_en;
  logic                  pop_en;

  // Status comes only from registered state, so hwr_ready has no path from ird/hwr_valid.
  assign hwr_ready   = (level_q != FULL_LVL);
  assign iavail      = (level_q != '0);
  assign inst        = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign almost_full = (level_q >= AF_LVL);
  assign err_udf     = err_udf_q;
  assign retired     = retired_q;

  // Flush wins over both ports, so neither handshake completes in a flush cycle.
  assign push_en = hwr_valid && hwr_ready && !flush;
  assign pop_en  = ird && iavail && !flush;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    err_udf_d = err_udf_q;
    retired_d = retired_q;
    if (flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      level_d   = '0;
      err_udf_d = 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        retired_d = retired_q + CNT_WIDTH'(1);
      end
      if (push_en && !pop_en) begin
        level_d = level_q + LW'(1);
      end else if (pop_en && !push_en) begin
        level_d = level_q - LW'(1);
      end
      // No bypass when empty: ird at level 0 is an underflow even if a push lands.
      if (ird && !iavail) begin
        err_udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      err_udf_q <= 1'b0;
      retired_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      err_udf_q <= err_udf_d;
      retired_q <= retired_d;
    end
  end

  // Storage carries no reset; level_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (reset && push_en) begin
      mem_q[wr_ptr_q] <= hwr_data;
    end
  end

`ifdef INST_QUEUE_STARVE_CNT_EN
  logic                 armed_q, armed_d;
  logic [CNT_WIDTH-1:0] starve_q, starve_d;

  // Counts empty cycles only once the host has delivered at least one word.
  always_comb begin
    armed_d  = armed_q;
    starve_d = starve_q;
    if (flush) begin
      armed_d  = 1'b0;
      starve_d = '0;
    end else begin
      if (push_en) begin
        armed_d = 1'b1;
      end
      if (armed_q && !iavail && (starve_q != '1)) begin
        starve_d = starve_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      armed_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      armed_q  <= armed_d;
      starve_q <= starve_d;
    end
  end

  assign starve_cnt = starve_q;
`else
  assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: expected words are queued on accepted pushes and
// compared on pops; status outputs are compared against a small behavioural model every cycle.
module tb_inst_queue;
  localparam int W   = 148;
  localparam int D   = 16;
  localparam int AFM = 2;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          hwr_valid;
  logic [W-1:0]  hwr_data;
  logic          hwr_ready;
  logic          flush;
  logic [W-1:0]  inst;
  logic          iavail;
  logic          ird;
  logic [4:0]    level;
  logic          almost_full;
  logic          err_udf;
  logic [CW-1:0] retired;
  logic [CW-1:0] starve_cnt;

  always #5 clk = ~clk;

  inst_queue #(
    .INST_WIDTH(W),
    .DEPTH(D),
    .AF_MARGIN(AFM),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hwr_valid(hwr_valid),
    .hwr_data(hwr_data),
    .hwr_ready(hwr_ready),
    .flush(flush),
    .inst(inst),
    .iavail(iavail),
    .ird(ird),
    .level(level),
    .almost_full(almost_full),
    .err_udf(err_udf),
    .retired(retired),
    .starve_cnt(starve_cnt)
  );

  logic [W-1:0] sb[$];
  int  m_retired = 0;
  bit  m_err     = 1'b0;
  bit  m_armed   = 1'b0;
  int  m_starve  = 0;
  int  n_checks  = 0;
  int  n_pass    = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  function automatic int exp_starve();
`ifdef INST_QUEUE_STARVE_CNT_EN
    return m_starve;
`else
    return 0;
`endif
  endfunction

  task automatic check_status();
    check("level", W'(level), W'(sb.size()));
    check("iavail", W'(iavail), W'(sb.size() != 0));
    check("hwr_ready", W'(hwr_ready), W'(sb.size() != D));
    check("almost_full", W'(almost_full), W'(sb.size() >= D - AFM));
    check("err_udf", W'(err_udf), W'(m_err));
    check("retired", W'(retired), W'(m_retired));
    check("starve_cnt", W'(starve_cnt), W'(exp_starve()));
    if (sb.size() != 0) check("head", inst, sb[0]);
  endtask

  // One clock: predict from pre-edge model state, advance, then compare status.
  task automatic tick();
    bit rst, psh, pp;
    rst = !reset;
    psh = hwr_valid && (sb.size() < D) && !flush;
    pp  = ird && (sb.size() > 0) && !flush;
    if (pp && !rst) check("pop_data", inst, sb[0]);
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_retired = 0; m_err = 1'b0; m_armed = 1'b0; m_starve = 0;
    end else if (flush) begin
      sb.delete();
      m_err = 1'b0; m_armed = 1'b0; m_starve = 0;
    end else begin
      if (m_armed && sb.size() == 0 && m_starve < 65535) m_starve++;
      if (ird && sb.size() == 0) m_err = 1'b1;
      if (pp) begin
        void'(sb.pop_front());
        m_retired = (m_retired + 1) % 65536;
      end
      if (psh) begin
        sb.push_back(hwr_data);
        m_armed = 1'b1;
      end
    end
    $display("t=%0t rst=%0b flush=%0b push=%0b pop=%0b level=%0d", $time, rst, flush,
             psh && !rst, pp && !rst, sb.size());
    check_status();
  endtask

  task automatic idle();
    hwr_valid = 1'b0; ird = 1'b0; flush = 1'b0;
  endtask

  task automatic drain_to(input int n);
    idle();
    ird = 1'b1;
    while (sb.size() > n) tick();
    ird = 1'b0;
  endtask

  initial begin
    int base;
    logic [W-1:0] w;
    reset = 1'b0; hwr_valid = 1'b1; hwr_data = rand_word(); flush = 1'b0; ird = 1'b0;
    // Reset while the host is presenting a word.
    repeat (3) tick();
    reset = 1'b1;
    idle();
    tick();

    // Fill to DEPTH; 17th word must be held off until one pop.
    for (int i = 0; i < D; i++) begin
      hwr_valid = 1'b1; hwr_data = rand_word();
      tick();
    end
    hwr_data = rand_word();
    tick();
    check("full_level", W'(level), W'(D));
    check("full_ready", W'(hwr_ready), W'(0));
    ird = 1'b1;
    tick();
    check("after_pop_ready", W'(hwr_ready), W'(1));
    ird = 1'b0;
    tick();
    drain_to(3);

    // Steady push+pop at level 3 across pointer wrap.
    base = int'(retired);
    hwr_valid = 1'b1; ird = 1'b1;
    for (int i = 0; i < 40; i++) begin
      hwr_data = rand_word();
      tick();
    end
    check("steady_level", W'(level), W'(3));
    check("retired_40", W'(CW'(int'(retired) - base)), W'(40));
    drain_to(0);

    // One-cycle latency into empty, then push+pop at level 1.
    w = rand_word();
    hwr_valid = 1'b1; hwr_data = w;
    tick();
    check("latency_iavail", W'(iavail), W'(1));
    check("latency_inst", inst, w);
    w = rand_word();
    hwr_data = w; ird = 1'b1;
    tick();
    check("swap_head", inst, w);
    check("swap_level", W'(level), W'(1));
    drain_to(0);

    // Underflow is sticky; flush clears it, drops a concurrent push, keeps retired.
    ird = 1'b1;
    tick();
    ird = 1'b0;
    tick();
    check("udf_sticky", W'(err_udf), W'(1));
    for (int i = 0; i < 5; i++) begin
      hwr_valid = 1'b1; hwr_data = rand_word();
      tick();
    end
    base = int'(retired);
    flush = 1'b1; hwr_data = rand_word();
    tick();
    idle();
    check("flush_level", W'(level), W'(0));
    check("flush_err", W'(err_udf), W'(0));
    check("flush_retired", W'(retired), W'(base));
    tick();

    // Starvation: push, pop, idle seven cycles, then flush.
    hwr_valid = 1'b1; hwr_data = rand_word();
    tick();
    idle(); ird = 1'b1;
    tick();
    idle();
    repeat (7) tick();
`ifdef INST_QUEUE_STARVE_CNT_EN
    check("starve_7", W'(starve_cnt), W'(7));
`else
    check("starve_7", W'(starve_cnt), W'(0));
`endif
    flush = 1'b1;
    tick();
    idle();
    check("starve_flush", W'(starve_cnt), W'(0));

    // Reset mid-operation behaves like power-up.
    for (int i = 0; i < 3; i++) begin
      hwr_valid = 1'b1; hwr_data = rand_word();
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1; idle();
    tick();
    check("rst_mid_level", W'(level), W'(0));
    check("rst_mid_retired", W'(retired), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
